scarf_regmap_param: RTL and testbench

//   Parametrised SCARF register-map slave: NUM_REGS byte registers behind one 7-bit slave ID.

---
 rtl/scarf_regmap_param_if.sv | 20 ++
 rtl/scarf_regmap_param.sv | 149 ++++++++++++++
 tb/tb_scarf_regmap_param.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scarf_regmap_param_if.sv
// SCARF byte-bus bundle between the bus deserialiser (master) and a register-map slave.
// read_data_out is the only slave-driven signal.
interface scarf_regmap_param_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_finished;
  logic [6:0] slave_id;
  logic       rnw;
  logic [7:0] read_data_out;

  modport master (
    output data_in, data_in_valid, data_in_finished, slave_id, rnw,
    input  read_data_out
  );

  modport slave (
    input  data_in, data_in_valid, data_in_finished, slave_id, rnw,
    output read_data_out
  );
endinterface

// File: rtl/scarf_regmap_param.sv
// SCARF register-map slave: NUM_REGS byte registers (RW / RO / W1C) behind one slave ID.
// RW writes are staged and become visible on cfg_regs_out atomically at transaction end.
module scarf_regmap_param #(
  parameter logic [6:0]            SLAVE_ID  = 7'h01,
  parameter int                    NUM_REGS  = 8,
  parameter int                    ADDR_W    = 4,
  parameter logic                  WRAP_EN   = 1'b0,
  parameter logic [NUM_REGS*8-1:0] RESET_VAL = '0,
  parameter logic [NUM_REGS-1:0]   RO_MASK   = '0,
  parameter logic [NUM_REGS-1:0]   W1C_MASK  = '0
) (
  input  logic                    clk,
  input  logic                    rst_sync,
  scarf_regmap_param_if.slave     bus,
  input  logic [NUM_REGS*8-1:0]   status_in,
  input  logic [NUM_REGS*8-1:0]   event_in,
  output logic [NUM_REGS*8-1:0]   cfg_regs_out,
  output logic                    commit_pulse
);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

  logic [NUM_REGS-1:0][7:0] stage_q, stage_d;
  logic [NUM_REGS-1:0][7:0] commit_q, commit_d;
  logic [NUM_REGS-1:0][7:0] w1c_q, w1c_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     first_q, first_d, final_q, final_d;
  logic                     dirty_q, dirty_d, pulse_q, pulse_d;
  logic                     valid_slave_s, byte_s, access_s, wr_s;
  logic [NUM_REGS-1:0]      sel_s;
  logic [7:0]               rd_reg_s;

  assign valid_slave_s = (bus.slave_id == SLAVE_ID);
  // A byte arriving together with finished is dropped.
  assign byte_s   = bus.data_in_valid & valid_slave_s & ~bus.data_in_finished;
  assign access_s = byte_s & ~first_q & ~final_q;
  assign wr_s     = access_s & ~bus.rnw;

  // Address decode; nothing is selected once the pointer is parked past the end.
  always_comb begin
    sel_s    = '0;
    rd_reg_s = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!final_q && (addr_q == ADDR_W'(i))) begin
        sel_s[i] = 1'b1;
        if (RO_MASK[i])       rd_reg_s = status_in[8*i +: 8];
        else if (W1C_MASK[i]) rd_reg_s = w1c_q[i];
        else                  rd_reg_s = stage_q[i];
      end else begin
        sel_s[i] = 1'b0;
      end
    end
  end

  // Combinational read byte.
  always_comb begin
    if (!valid_slave_s || !bus.rnw) bus.read_data_out = 8'h00;
    else if (first_q)               bus.read_data_out = {1'b0, SLAVE_ID};
    else                            bus.read_data_out = rd_reg_s;
  end

  // Transaction pointer, staging and commit.
  always_comb begin
    addr_d   = addr_q;
    first_d  = first_q;
    final_d  = final_q;
    dirty_d  = dirty_q;
    stage_d  = stage_q;
    commit_d = commit_q;
    pulse_d  = bus.data_in_finished & dirty_q;
    if (bus.data_in_finished) begin
      addr_d  = '0;
      first_d = 1'b1;
      final_d = 1'b0;
      dirty_d = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dirty_q && !RO_MASK[i] && !W1C_MASK[i]) commit_d[i] = stage_q[i];
        else                                        commit_d[i] = commit_q[i];
      end
    end else if (byte_s && first_q) begin
      addr_d  = bus.data_in[ADDR_W-1:0];
      first_d = 1'b0;
      final_d = ({1'b0, bus.data_in[ADDR_W-1:0]} >= NUM_REGS_W);
    end else if (access_s) begin
      if (addr_q == LAST_ADDR) begin
        if (WRAP_EN) addr_d  = '0;
        else         final_d = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_s && sel_s[i] && !RO_MASK[i] && !W1C_MASK[i]) begin
          stage_d[i] = bus.data_in;
          dirty_d    = 1'b1;
        end else begin
          stage_d[i] = stage_q[i];
        end
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // Sticky bits: events set, write-one clears, set wins over a same-cycle clear.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (W1C_MASK[i]) begin
        w1c_d[i] = (w1c_q[i] & ~((wr_s && sel_s[i]) ? bus.data_in : 8'h00))
                 | event_in[8*i +: 8];
      end else begin
        w1c_d[i] = w1c_q[i];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      stage_q  <= RESET_VAL;
      commit_q <= RESET_VAL;
      w1c_q    <= RESET_VAL;
      addr_q   <= '0;
      first_q  <= 1'b1;
      final_q  <= 1'b0;
      dirty_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      commit_q <= commit_d;
      w1c_q    <= w1c_d;
      addr_q   <= addr_d;
      first_q  <= first_d;
      final_q  <= final_d;
      dirty_q  <= dirty_d;
      pulse_q  <= pulse_d;
    end
  end

  // Output view: RO slices read as zero, W1C slices are live.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (RO_MASK[i])       cfg_regs_out[8*i +: 8] = 8'h00;
      else if (W1C_MASK[i]) cfg_regs_out[8*i +: 8] = w1c_q[i];
      else                  cfg_regs_out[8*i +: 8] = commit_q[i];
    end
  end

  assign commit_pulse = pulse_q;
endmodule

// File: tb/tb_scarf_regmap_param.sv
// Bench for scarf_regmap_param: a no-wrap and a wrap instance share stimulus; a directed
// vector table covers the corner cases, then random transactions run against a reference model.
module tb_scarf_regmap_param;
  localparam int          NR  = 8;
  localparam logic [63:0] RV  = 64'h7766_5544_0033_00A5;
  localparam logic [7:0]  ROM = 8'h02;
  localparam logic [7:0]  W1M = 8'h08;

  logic        clk = 1'b0;
  logic        rst_sync;
  logic [63:0] status_in, event_in, cfg0, cfg1;
  logic        pul0, pul1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  scarf_regmap_param_if bus0 ();
  scarf_regmap_param_if bus1 ();

  scarf_regmap_param #(.SLAVE_ID(7'h01), .NUM_REGS(NR), .ADDR_W(4), .WRAP_EN(1'b0),
    .RESET_VAL(RV), .RO_MASK(ROM), .W1C_MASK(W1M)) dut0 (
    .clk(clk), .rst_sync(rst_sync), .bus(bus0), .status_in(status_in),
    .event_in(event_in), .cfg_regs_out(cfg0), .commit_pulse(pul0));

  scarf_regmap_param #(.SLAVE_ID(7'h01), .NUM_REGS(NR), .ADDR_W(4), .WRAP_EN(1'b1),
    .RESET_VAL(RV), .RO_MASK(ROM), .W1C_MASK(W1M)) dut1 (
    .clk(clk), .rst_sync(rst_sync), .bus(bus1), .status_in(status_in),
    .event_in(event_in), .cfg_regs_out(cfg1), .commit_pulse(pul1));

  typedef struct {
    logic       chk, rst, v, fin;
    logic [6:0] sid;
    logic       rnw;
    logic [7:0] d, ev3, rd0, rd1;
    logic       pul;
    int         cidx;
    logic [7:0] cval;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic chk, logic rst, logic v, logic fin, logic [6:0] sid,
                              logic rnw, logic [7:0] d, logic [7:0] ev3, logic [7:0] rd0,
                              logic [7:0] rd1, logic pul, int cidx, logic [7:0] cval);
    vec_t e;
    e = '{chk, rst, v, fin, sid, rnw, d, ev3, rd0, rd1, pul, cidx, cval};
    tbl.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic f, input logic [6:0] sid,
                       input logic rw, input logic [7:0] d);
    rst_sync = r;
    bus0.data_in = d;  bus0.data_in_valid = v;  bus0.data_in_finished = f;
    bus0.slave_id = sid;  bus0.rnw = rw;
    bus1.data_in = d;  bus1.data_in_valid = v;  bus1.data_in_finished = f;
    bus1.slave_id = sid;  bus1.rnw = rw;
  endtask

  // Reference model: a transaction is a start address plus a byte count.
  logic [7:0] m_com[2][NR];
  logic [7:0] m_stg[2][NR];
  logic [7:0] m_w1c[2][NR];
  int         m_cnt[2];
  int         m_start[2];
  bit         m_dirty[2];
  bit         m_pul[2];

  // Register touched by the k-th data byte (k>=1) of the transaction, or -1.
  function automatic int eff(int m, int k);
    int off;
    if (k < 1 || m_start[m] >= NR) return -1;
    off = m_start[m] + k - 1;
    if (m == 1) return off % NR;
    return (off < NR) ? off : -1;
  endfunction

  function automatic logic [7:0] exp_rd(int m);
    int a;
    if (bus0.slave_id != 7'h01 || !bus0.rnw) return 8'h00;
    if (m_cnt[m] == 0) return 8'h01;
    a = eff(m, m_cnt[m]);
    if (a < 0) return 8'h00;
    if (ROM[a]) return status_in[8*a +: 8];
    if (W1M[a]) return m_w1c[m][a];
    return m_stg[m][a];
  endfunction

  function automatic logic [63:0] exp_cfg(int m);
    logic [63:0] r;
    for (int i = 0; i < NR; i++)
      r[8*i +: 8] = ROM[i] ? 8'h00 : (W1M[i] ? m_w1c[m][i] : m_com[m][i]);
    return r;
  endfunction

  task automatic model_step(int m);
    int a;
    logic [7:0] clr;
    a = -1;
    clr = 8'h00;
    if (rst_sync) begin
      for (int i = 0; i < NR; i++) begin
        m_com[m][i] = RV[8*i +: 8];
        m_stg[m][i] = RV[8*i +: 8];
        m_w1c[m][i] = RV[8*i +: 8];
      end
      m_cnt[m] = 0;  m_dirty[m] = 0;  m_pul[m] = 0;
      return;
    end
    m_pul[m] = bus0.data_in_finished && m_dirty[m];
    if (bus0.data_in_finished) begin
      if (m_dirty[m])
        for (int i = 0; i < NR; i++) if (!ROM[i] && !W1M[i]) m_com[m][i] = m_stg[m][i];
      m_cnt[m] = 0;
      m_dirty[m] = 0;
    end else if (bus0.data_in_valid && bus0.slave_id == 7'h01) begin
      if (m_cnt[m] == 0) begin
        m_start[m] = int'(bus0.data_in[3:0]);
        m_cnt[m] = 1;
      end else begin
        a = eff(m, m_cnt[m]);
        m_cnt[m]++;
        if (a >= 0 && !bus0.rnw) begin
          if (W1M[a]) clr = bus0.data_in;
          else if (!ROM[a]) begin
            m_stg[m][a] = bus0.data_in;
            m_dirty[m] = 1;
          end
        end
      end
    end
    for (int i = 0; i < NR; i++)
      if (W1M[i]) m_w1c[m][i] = (m_w1c[m][i] & ~((i == a) ? clr : 8'h00)) | event_in[8*i +: 8];
  endtask

  task automatic rand_step(input logic r, input logic v, input logic f, input logic [6:0] sid,
                           input logic rw, input logic [7:0] d);
    event_in = ($urandom_range(0, 3) == 0) ? ({$urandom, $urandom} & {$urandom, $urandom}) : 64'h0;
    drive(r, v, f, sid, rw, d);
    #4;
    chk("rnd_rd_nowrap", bus0.read_data_out, exp_rd(0));
    chk("rnd_rd_wrap", bus1.read_data_out, exp_rd(1));
    chk("rnd_cfg_nowrap", cfg0, exp_cfg(0));
    chk("rnd_cfg_wrap", cfg1, exp_cfg(1));
    chk("rnd_pulse_nowrap", pul0, m_pul[0]);
    chk("rnd_pulse_wrap", pul1, m_pul[1]);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] sid;
    logic       rw;
    int         nb;
    logic [7:0] d;
    vec_t       e;

    //  chk rst v fin sid   rnw d      ev3    rd0    rd1    pul cidx cval
    add(0, 1, 0, 0, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'hA5);
    add(1, 0, 0, 0, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'hA5);
    add(1, 0, 1, 0, 7'h01, 0, 8'h04, 8'h00, 8'h00, 8'h00, 0, 4, 8'h44);
    add(1, 0, 1, 0, 7'h01, 0, 8'h11, 8'h00, 8'h00, 8'h00, 0, 4, 8'h44);
    add(1, 0, 1, 0, 7'h01, 0, 8'h22, 8'h00, 8'h00, 8'h00, 0, 4, 8'h44);
    add(1, 0, 1, 0, 7'h01, 0, 8'h33, 8'h00, 8'h00, 8'h00, 0, 4, 8'h44);
    add(1, 0, 0, 1, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4, 8'h44);
    add(1, 0, 0, 0, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4, 8'h11);
    add(1, 0, 0, 0, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 5, 8'h22);
    add(1, 0, 0, 0, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 6, 8'h33);
    add(1, 0, 1, 0, 7'h01, 1, 8'h06, 8'h00, 8'h01, 8'h01, 0, 6, 8'h33);
    add(1, 0, 1, 0, 7'h01, 1, 8'h00, 8'h00, 8'h33, 8'h33, 0, 6, 8'h33);
    add(1, 0, 1, 0, 7'h01, 1, 8'h00, 8'h00, 8'h77, 8'h77, 0, 6, 8'h33);
    add(1, 0, 1, 0, 7'h01, 1, 8'h00, 8'h00, 8'h00, 8'hA5, 0, 6, 8'h33);
    add(1, 0, 1, 0, 7'h01, 1, 8'h00, 8'h00, 8'h00, 8'h5C, 0, 6, 8'h33);
    add(1, 0, 0, 1, 7'h01, 1, 8'h00, 8'h00, 8'h00, 8'h33, 0, 6, 8'h33);
    add(1, 0, 0, 0, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'hA5);
    add(1, 0, 0, 0, 7'h01, 0, 8'h00, 8'h01, 8'h00, 8'h00, 0, 3, 8'h00);
    add(1, 0, 0, 0, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 3, 8'h01);
    add(1, 0, 1, 0, 7'h01, 0, 8'h03, 8'h00, 8'h00, 8'h00, 0, 3, 8'h01);
    add(1, 0, 1, 0, 7'h01, 0, 8'h01, 8'h01, 8'h00, 8'h00, 0, 3, 8'h01);
    add(1, 0, 0, 1, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 3, 8'h01);
    add(1, 0, 1, 0, 7'h01, 0, 8'h03, 8'h00, 8'h00, 8'h00, 0, 3, 8'h01);
    add(1, 0, 1, 0, 7'h01, 0, 8'h01, 8'h00, 8'h00, 8'h00, 0, 3, 8'h01);
    add(1, 0, 0, 1, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 3, 8'h00);
    add(1, 0, 1, 0, 7'h01, 1, 8'h01, 8'h00, 8'h01, 8'h01, 0, 3, 8'h00);
    add(1, 0, 1, 0, 7'h01, 1, 8'h00, 8'h00, 8'h5C, 8'h5C, 0, 1, 8'h00);
    add(1, 0, 0, 1, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00);
    add(1, 0, 1, 0, 7'h01, 0, 8'h01, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00);
    add(1, 0, 1, 0, 7'h01, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00);
    add(1, 0, 0, 1, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00);
    add(1, 0, 0, 0, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00);
    add(1, 0, 1, 0, 7'h01, 0, 8'h04, 8'h00, 8'h00, 8'h00, 0, 4, 8'h11);
    add(1, 0, 1, 0, 7'h01, 0, 8'h12, 8'h00, 8'h00, 8'h00, 0, 4, 8'h11);
    add(1, 0, 1, 0, 7'h01, 0, 8'h34, 8'h00, 8'h00, 8'h00, 0, 4, 8'h11);
    add(1, 1, 0, 0, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4, 8'h11);
    add(1, 0, 0, 1, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4, 8'h44);
    add(1, 0, 0, 0, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 5, 8'h55);
    add(1, 0, 1, 0, 7'h02, 1, 8'h06, 8'h00, 8'h00, 8'h00, 0, 0, 8'hA5);
    add(1, 0, 1, 0, 7'h02, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'hA5);
    add(1, 0, 1, 0, 7'h02, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 8'hA5);
    add(1, 0, 1, 0, 7'h01, 1, 8'h06, 8'h00, 8'h01, 8'h01, 0, 6, 8'h66);
    add(1, 0, 1, 0, 7'h01, 1, 8'h00, 8'h00, 8'h66, 8'h66, 0, 6, 8'h66);
    add(1, 0, 0, 1, 7'h01, 1, 8'h00, 8'h00, 8'h77, 8'h77, 0, 6, 8'h66);
    add(1, 0, 0, 0, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 6, 8'h66);
    add(1, 0, 1, 0, 7'h01, 0, 8'h04, 8'h00, 8'h00, 8'h00, 0, 4, 8'h44);
    add(1, 0, 1, 1, 7'h01, 0, 8'h99, 8'h00, 8'h00, 8'h00, 0, 4, 8'h44);
    add(1, 0, 0, 0, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4, 8'h44);
    add(1, 0, 1, 0, 7'h01, 1, 8'h04, 8'h00, 8'h01, 8'h01, 0, 4, 8'h44);
    add(1, 0, 1, 0, 7'h01, 1, 8'h00, 8'h00, 8'h44, 8'h44, 0, 4, 8'h44);
    add(1, 0, 0, 1, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4, 8'h44);
    add(1, 0, 0, 0, 7'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4, 8'h44);

    status_in = 64'h0000_0000_0000_5C00;
    event_in  = 64'h0;
    drive(1'b1, 1'b0, 1'b0, 7'h01, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    for (int r = 0; r < tbl.size(); r++) begin
      e = tbl[r];
      event_in = {32'h0, e.ev3, 24'h0};
      drive(e.rst, e.v, e.fin, e.sid, e.rnw, e.d);
      #4;
      if (e.chk) begin
        chk($sformatf("vec%0d_rd_nowrap", r), bus0.read_data_out, e.rd0);
        chk($sformatf("vec%0d_rd_wrap", r), bus1.read_data_out, e.rd1);
        chk($sformatf("vec%0d_pulse_nowrap", r), pul0, e.pul);
        chk($sformatf("vec%0d_pulse_wrap", r), pul1, e.pul);
        chk($sformatf("vec%0d_cfg%0d_nowrap", r, e.cidx), cfg0[8*e.cidx +: 8], e.cval);
        chk($sformatf("vec%0d_cfg%0d_wrap", r, e.cidx), cfg1[8*e.cidx +: 8], e.cval);
      end
      @(posedge clk);
      #1;
    end

    // Bring DUTs and model to a common reset state, then run random transactions.
    event_in = 64'h0;
    drive(1'b1, 1'b0, 1'b0, 7'h01, 1'b0, 8'h00);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    for (int t = 0; t < 300; t++) begin
      sid = ($urandom_range(0, 4) == 0) ? 7'h02 : 7'h01;
      rw  = 1'($urandom_range(0, 1));
      nb  = $urandom_range(1, 10);
      status_in = {$urandom, $urandom};
      for (int b = 0; b < nb; b++) begin
        if (b == 0) d = 8'($urandom_range(0, 9)) | 8'($urandom_range(0, 15) << 4);
        else        d = 8'($urandom);
        rand_step(($urandom_range(0, 60) == 0), 1'b1, 1'b0, sid, rw, d);
        if ($urandom_range(0, 3) == 0) rand_step(1'b0, 1'b0, 1'b0, sid, rw, 8'($urandom));
      end
      rand_step(1'b0, ($urandom_range(0, 3) == 0), 1'b1, sid, rw, 8'($urandom));
      rand_step(1'b0, 1'b0, 1'b0, 7'h01, 1'b0, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
